yarp_mc_ctrl: RTL
=================

# yarp_mc_ctrl

Multi-cycle sequencer for the yarp core. It steps each instruction through fetch, execute, optional memory access and writeback. It drives the instruction-memory and data-memory request handshakes, the instruction-register load strobe, and the PC and register-file write enables. Instruction classification comes from the instruction-decode block's type flags and opcode. It also detects illegal encodings and bus timeouts and halts the core on either.

## Interface
Parameters:
- TIMEOUT, 256: maximum wait cycles in any memory-wait state before a bus error; legal range 2..65536.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- en_i  in  1  run enable; sampled in IDLE and WB.
- imem_req_o  out  1  instruction fetch request.
- imem_gnt_i  in  1  instruction memory accepts the request.
- imem_rvalid_i  in  1  instruction data valid.
- instr_we_o  out  1  load the instruction register; equals imem_rvalid_i while in IWAIT.
- op_i  in  7  opcode from decode.
- r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i  in  1 each  decode type flags.
- dmem_req_o  out  1  data memory request.
- dmem_wr_o  out  1  request is a store; valid only while dmem_req_o=1, 0 otherwise.
- dmem_gnt_i  in  1  data memory accepts the request.
- dmem_rvalid_i  in  1  load data valid, or store acknowledge.
- pc_we_o  out  1  PC update strobe.
- rf_we_o  out  1  register-file write strobe.
- illegal_o  out  1  sticky illegal-instruction flag.
- bus_err_o  out  1  sticky memory-timeout flag.
- state_o  out  4  current state encoding.
- retired_o  out  32  retired-instruction counter.

## Operation
States and encodings: IDLE=0, FETCH=1, IWAIT=2, EXEC=3, MEM=4, MWAIT=5, WB=6, HALT=7.

All outputs are Moore decodes of the registered state. instr_we_o is the one exception: it is the Mealy term IWAIT & imem_rvalid_i.

- **IDLE:** all strobes 0. en_i=1 → FETCH.
- **FETCH:** imem_req_o=1. imem_gnt_i=1 → IWAIT.
- **IWAIT:** imem_rvalid_i=1 → instr_we_o=1, then → EXEC.
- **EXEC:** evaluates the type flags, which come from the freshly loaded instruction register.
  - Flags not exactly one-hot (none set or more than one set) → HALT with illegal_o set.
  - op_i=0000011 (load), or s_type_i=1 → MEM.
  - Otherwise → WB.
- **MEM:** dmem_req_o=1 and dmem_wr_o=s_type_i. dmem_gnt_i=1 → MWAIT.
- **MWAIT:** dmem_rvalid_i=1 → WB. Stores also wait for the acknowledge.
- **WB:**
  - pc_we_o=1.
  - rf_we_o = !(s_type_i | b_type_i).
  - retired_o increments by 1 and wraps from 0xFFFFFFFF to 0.
  - Next state: en_i=1 → FETCH, else IDLE.
- **HALT:** all strobes 0. The state is held until reset_n is asserted.

Timeout:
- A wait counter of width $clog2(TIMEOUT) runs in FETCH, IWAIT, MEM and MWAIT.
- It clears on every state transition.
- If the counter reaches TIMEOUT-1 without the exit condition, the next state is HALT and bus_err_o is set.
- If the exit condition and the timeout coincide in the same cycle, the exit condition wins.

Other rules:
- illegal_o and bus_err_o are sticky and are cleared only by reset.
- en_i deasserting mid-instruction does not abort it. It is honoured only in WB.
- Grant and valid inputs arriving in any state other than the one that consumes them are ignored.

## Timing
Reset values: state=IDLE, every strobe 0, illegal_o=0, bus_err_o=0, retired_o=0, wait counter 0.

Reset asserted mid-instruction returns the block to IDLE immediately. No strobe pulses after the asserting edge.

Zero-wait latency per instruction, counted from the first FETCH cycle to the WB cycle inclusive:
- ALU, branch, LUI/AUIPC and jump: 4 cycles.
- Load and store: 6 cycles.

Each wait cycle adds one cycle.

- imem_req_o and dmem_req_o stay high until the grant. They drop in the cycle after the grant.
- rvalid in the same cycle as gnt is not accepted; it is sampled only in the following wait state.
- pc_we_o and rf_we_o are one-cycle pulses per instruction.
- Back-to-back instructions: WB is followed directly by FETCH, with no bubble.

## Test plan
- **ALU instruction:** en_i=1, gnt and rvalid each one cycle after the request, r_type_i=1 → state sequence 0,1,2,3,6,1. rf_we_o=1 and pc_we_o=1 in the WB cycle. retired_o=1.
- **Store:** s_type_i=1, dmem_gnt_i delayed 3 cycles → dmem_req_o high 4 cycles with dmem_wr_o=1. In WB: rf_we_o=0, pc_we_o=1.
- **Load:** op_i=0000011, i_type_i=1 → dmem_wr_o=0. WB is reached 6 cycles after FETCH. rf_we_o=1.
- **Illegal instruction:** all flags 0 in EXEC → state 7 and illegal_o=1. Further gnt/rvalid activity produces no strobes. reset_n low → state 0 and illegal_o=0.
- **Bus timeout:** TIMEOUT=4 with imem_gnt_i held 0 → HALT on the 4th FETCH cycle and bus_err_o=1. Repeat with gnt in the 4th cycle → IWAIT and no error.
- **Enable and counter wrap:** en_i dropped during MWAIT → the instruction completes, then IDLE. retired_o forced near 0xFFFFFFFF by running the sequence → wraps to 0.

Source files
------------

// File: rtl/yarp_mc_ctrl.sv
// Multi-cycle instruction sequencer for the yarp core: fetch, execute, optional
// data-memory access and writeback, with halt on illegal encodings or bus timeouts.
module yarp_mc_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  output logic        instr_we_o,
  input  logic [6:0]  op_i,
  input  logic        r_type_i,
  input  logic        i_type_i,
  input  logic        s_type_i,
  input  logic        b_type_i,
  input  logic        u_type_i,
  input  logic        j_type_i,
  output logic        dmem_req_o,
  output logic        dmem_wr_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  output logic        pc_we_o,
  output logic        rf_we_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [3:0]  state_o,
  output logic [31:0] retired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    IWAIT = 4'd2,
    EXEC  = 4'd3,
    MEM   = 4'd4,
    MWAIT = 4'd5,
    WB    = 4'd6,
    HALT  = 4'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st;
  logic             wait_exit;
  logic             timed_out;
  logic             flags_legal;
  logic             needs_mem;

  assign timed_out   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign flags_legal = $onehot({r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i});
  assign needs_mem   = (op_i == OP_LOAD) || s_type_i;

  // Exit condition of whichever wait state is current; it beats a same-cycle timeout.
  always_comb begin
    wait_st   = 1'b0;
    wait_exit = 1'b0;
    case (state)
      FETCH:   begin wait_st = 1'b1; wait_exit = imem_gnt_i;    end
      IWAIT:   begin wait_st = 1'b1; wait_exit = imem_rvalid_i; end
      MEM:     begin wait_st = 1'b1; wait_exit = dmem_gnt_i;    end
      MWAIT:   begin wait_st = 1'b1; wait_exit = dmem_rvalid_i; end
      default: begin wait_st = 1'b0; wait_exit = 1'b0;          end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
      retired_o <= '0;
    end else begin
      case (state)
        IDLE:  if (en_i) state <= FETCH;
        FETCH: if (imem_gnt_i) state <= IWAIT;
        IWAIT: if (imem_rvalid_i) state <= EXEC;
        EXEC: begin
          if (!flags_legal) begin
            state     <= HALT;
            illegal_o <= 1'b1;
          end else if (needs_mem) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM:   if (dmem_gnt_i) state <= MWAIT;
        MWAIT: if (dmem_rvalid_i) state <= WB;
        WB: begin
          retired_o <= retired_o + 32'd1;
          state     <= en_i ? FETCH : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase

      if (wait_st) begin
        if (wait_exit) begin
          wait_cnt <= '0;
        end else if (timed_out) begin
          wait_cnt  <= '0;
          state     <= HALT;
          bus_err_o <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state_o    = state;
  assign imem_req_o = (state == FETCH);
  assign instr_we_o = (state == IWAIT) && imem_rvalid_i;
  assign dmem_req_o = (state == MEM);
  assign dmem_wr_o  = (state == MEM) && s_type_i;
  assign pc_we_o    = (state == WB);
  assign rf_we_o    = (state == WB) && !(s_type_i || b_type_i);

endmodule
